// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a valid/ready load handshake.
// Streams back-to-back words with no idle gap between frames.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             shift,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sreg_adv;

    assign last_bit   = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign load_ready = (state_q == S_IDLE) || last_bit;
    assign accept     = load_valid && load_ready;

    // Shift toward the output end; the vacated end fills with zero.
    assign sreg_adv = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (1'b1)
            (state_q == S_IDLE): begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            last_bit: begin
                done_d = 1'b1;
                if (accept) begin
                    sreg_d = data_in;
                    cnt_d  = '0;
                end else begin
                    sreg_d  = sreg_adv;
                    state_d = S_IDLE;
                end
            end
            default: begin
                sreg_d = sreg_adv;
                cnt_d  = cnt_q + CW'(1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign shift = (state_q == S_SHIFT);
    assign busy  = (state_q == S_SHIFT);
    assign done  = done_q;
    assign out   = (state_q == S_SHIFT) &&
                   (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances
// checked against a queue-of-bits model of the expected serial stream.
module tb_piso_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       load_valid = 1'b0;
    logic       rdy_m, out_m, sh_m, busy_m, done_m;
    logic       rdy_l, out_l, sh_l, busy_l, done_l;

    int vec  = 0;
    int miss = 0;

    // Each entry is {last-bit-of-frame, bit}; the head is the bit on out now.
    logic [1:0] qm[$];
    logic [1:0] ql[$];
    logic       dm = 1'b0;
    logic       dl = 1'b0;
    logic       acc;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .data_in(data_in),
        .load_valid(load_valid), .load_ready(rdy_m),
        .out(out_m), .shift(sh_m), .busy(busy_m), .done(done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in),
        .load_valid(load_valid), .load_ready(rdy_l),
        .out(out_l), .shift(sh_l), .busy(busy_l), .done(done_l)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("msb_out",   out_m,  (qm.size() > 0) ? qm[0][0] : 1'b0);
        chk("msb_shift", sh_m,   qm.size() > 0);
        chk("msb_busy",  busy_m, qm.size() > 0);
        chk("msb_done",  done_m, dm);
        chk("lsb_out",   out_l,  (ql.size() > 0) ? ql[0][0] : 1'b0);
        chk("lsb_shift", sh_l,   ql.size() > 0);
        chk("lsb_busy",  busy_l, ql.size() > 0);
        chk("lsb_done",  done_l, dl);
    endtask

    task automatic model_reset();
        qm.delete();
        ql.delete();
        dm = 1'b0;
        dl = 1'b0;
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs.
    task automatic cycle(input logic v, input logic [7:0] d);
        logic [7:0] w;
        load_valid = v;
        data_in    = d;
        w          = d;
        chk("msb_ready", rdy_m, qm.size() <= 1);
        chk("lsb_ready", rdy_l, ql.size() <= 1);
        acc = v && rst && (qm.size() <= 1);
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            dm = 1'b0;
            dl = 1'b0;
            if (qm.size() > 0) begin
                dm = qm[0][1];
                void'(qm.pop_front());
            end
            if (ql.size() > 0) begin
                dl = ql[0][1];
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < 8; i++) begin
                    qm.push_back({i == 7, w[7 - i]});
                    ql.push_back({i == 7, w[i]});
                end
            end
        end
        chk_outs();
    endtask

    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            cycle(1'b1, d);
            ok = acc;
        end
        if (!ok) begin
            vec++;
            miss++;
            $error("FAIL send_timeout observed=no_accept expected=accept");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    initial begin
        #1;
        for (int i = 0; i < 5; i++)
            cycle(1'($urandom), 8'($urandom));
        rst = 1'b1;

        send(8'hA5);
        idle(11);

        send(8'hA5);
        send(8'h3C);
        idle(10);

        send(8'h01);
        idle(10);

        send(8'h5A);
        cycle(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hFF);
        idle(5);

        send(8'hA5);
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        rst = 1'b0;
        #1;
        model_reset();
        chk_outs();
        idle(3);
        rst = 1'b1;
        send(8'h0F);
        idle(10);

        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 3) != 0), 8'($urandom));
        load_valid = 1'b0;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
